// File: rtl/cov_stall_monitor.sv
// Coverage stagnation / round watchdog monitor driving a latched msip request.
// Per-channel stall counters scale their threshold with the coverage magnitude.
module cov_stall_monitor #(
  parameter int NUM_CH      = 2,
  parameter int COV_W       = 30,
  parameter int CNT_W       = 32,
  parameter int BASE_WAIT   = 1000,
  parameter int SCALE_SHIFT = 19,
  parameter int WDOG_LIMIT  = 50000,
  parameter int ALL_MODE    = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH*COV_W-1:0] cov,
  input  logic [63:0]             tohost,
  input  logic                    irq_ack,
  output logic                    irq,
  output logic [NUM_CH:0]         irq_cause,
  output logic [15:0]             fired_count
);

  localparam int THR_W = CNT_W + COV_W;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    REARM
  } state_t;

  state_t state_q, state_d;

  logic              irq_q, irq_d;
  logic [NUM_CH:0]   cause_q, cause_d;
  logic [15:0]       fired_q, fired_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic [NUM_CH-1:0] stalled;
  logic              round_done;
  logic              ack;
  logic              wd_hit;
  logic              stall_sel;
  logic              trigger;
  logic              unused_tohost;

  assign round_done    = tohost[0];
  assign unused_tohost = ^tohost[63:1];
  assign ack           = (state_q == ASSERT) && irq_ack;
  assign wd_hit        = (wdog_q >= CNT_W'(WDOG_LIMIT));

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    logic [COV_W-1:0] cov_ch;
    logic [COV_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [THR_W-1:0] thr;

    assign cov_ch = cov[g*COV_W +: COV_W];

    // Wide product so large coverage values never wrap the threshold
    assign thr = THR_W'(BASE_WAIT)
               * ((THR_W'(cov_ch) >> SCALE_SHIFT) + THR_W'(1));

    assign stalled[g] = (THR_W'(cnt_q) >= thr);

    always_comb begin
      pre_d = pre_q;
      cnt_d = cnt_q;
      if (enable) begin
        if (round_done) begin
          cnt_d = '0;
        end else if (cov_ch != pre_q) begin
          pre_d = cov_ch;
          cnt_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (ack) begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pre_q <= '0;
        cnt_q <= '0;
      end else begin
        pre_q <= pre_d;
        cnt_q <= cnt_d;
      end
    end
  end

  always_comb begin
    wdog_d = wdog_q;
    if (enable) begin
      if (round_done) begin
        wdog_d = '0;
      end else if (wdog_q != '1) begin
        wdog_d = wdog_q + CNT_W'(1);
      end
    end
    if (ack) begin
      wdog_d = '0;
    end
  end

  assign stall_sel = (ALL_MODE != 0) ? (&stalled) : (|stalled);
  assign trigger   = enable && !round_done && (wd_hit || stall_sel);

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    cause_d = cause_q;
    fired_d = fired_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ASSERT;
          irq_d   = 1'b1;
          cause_d = {wd_hit, stalled};
          if (fired_q != 16'hFFFF) begin
            fired_d = fired_q + 16'd1;
          end
        end
      end
      ASSERT: begin
        if (ack) begin
          state_d = REARM;
          irq_d   = 1'b0;
        end
      end
      REARM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      cause_q <= '0;
      fired_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      cause_q <= cause_d;
      fired_q <= fired_d;
      wdog_q  <= wdog_d;
    end
  end

  assign irq         = irq_q;
  assign irq_cause   = cause_q;
  assign fired_count = fired_q;

endmodule

// File: tb/tb_cov_stall_monitor.sv
// Bench for cov_stall_monitor: ANY and ALL instances share stimulus,
// each checked by an integer reference model through an event scoreboard.
module tb_cov_stall_monitor;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int NW  = 12;
  localparam int BW  = 20;
  localparam int SS  = 5;
  localparam int WL  = 400;

  typedef struct {
    int         cyc;
    logic [2:0] cause;
    int         fired;
  } ev_t;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [NCH*CW-1:0] cov;
  logic [63:0]     tohost;
  logic            ack_a, ack_b;
  logic            irq_a, irq_b;
  logic [NCH:0]    cause_a, cause_b;
  logic [15:0]     fired_a, fired_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int         m_cnt[2][NCH];
  int         m_pre[2][NCH];
  int         m_wd[2];
  int         m_mode[2];
  bit         m_irq[2];
  logic [2:0] m_cause[2];
  int         m_fired[2];
  int         last_rise[2];
  ev_t        q0[$];
  ev_t        q1[$];

  always #5 clock = ~clock;

  cov_stall_monitor #(
    .NUM_CH(NCH), .COV_W(CW), .CNT_W(NW), .BASE_WAIT(BW),
    .SCALE_SHIFT(SS), .WDOG_LIMIT(WL), .ALL_MODE(0)
  ) u_any (
    .clock(clock), .reset(reset), .enable(enable), .cov(cov),
    .tohost(tohost), .irq_ack(ack_a), .irq(irq_a),
    .irq_cause(cause_a), .fired_count(fired_a)
  );

  cov_stall_monitor #(
    .NUM_CH(NCH), .COV_W(CW), .CNT_W(NW), .BASE_WAIT(BW),
    .SCALE_SHIFT(SS), .WDOG_LIMIT(WL), .ALL_MODE(1)
  ) u_all (
    .clock(clock), .reset(reset), .enable(enable), .cov(cov),
    .tohost(tohost), .irq_ack(ack_b), .irq(irq_b),
    .irq_cause(cause_b), .fired_count(fired_b)
  );

  function automatic bit get_irq(input int m);
    return (m == 0) ? irq_a : irq_b;
  endfunction

  function automatic logic [2:0] get_cause(input int m);
    return (m == 0) ? cause_a : cause_b;
  endfunction

  function automatic int get_fired(input int m);
    return (m == 0) ? int'(fired_a) : int'(fired_b);
  endfunction

  function automatic bit get_ack(input int m);
    return (m == 0) ? ack_a : ack_b;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[m][i] = 0;
        m_pre[m][i] = 0;
      end
      m_wd[m]    = 0;
      m_mode[m]  = 0;
      m_irq[m]   = 1'b0;
      m_cause[m] = '0;
      m_fired[m] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock of spec behaviour from the inputs currently driven
  task automatic model_step(input int m);
    logic [2:0] st;
    int  ns, c, limit;
    bit  td, trig, ackm;
    ev_t e;
    st    = '0;
    ns    = 0;
    td    = tohost[0];
    limit = (1 << NW) - 1;
    for (int i = 0; i < NCH; i++) begin
      c     = int'(cov[i*CW +: CW]);
      st[i] = (m_cnt[m][i] >= BW * ((c >> SS) + 1));
      ns   += int'(st[i]);
    end
    st[NCH] = (m_wd[m] >= WL);
    ackm = (m_mode[m] == 1) && get_ack(m);
    trig = (m_mode[m] == 0) && enable && !td
         && (st[NCH] || ((m == 1) ? (ns == NCH) : (ns > 0)));
    for (int i = 0; i < NCH; i++) begin
      c = int'(cov[i*CW +: CW]);
      if (enable) begin
        if (td) m_cnt[m][i] = 0;
        else if (c != m_pre[m][i]) begin
          m_pre[m][i] = c;
          m_cnt[m][i] = 0;
        end else if (m_cnt[m][i] < limit) m_cnt[m][i]++;
      end
      if (ackm) m_cnt[m][i] = 0;
    end
    if (enable) begin
      if (td) m_wd[m] = 0;
      else if (m_wd[m] < limit) m_wd[m]++;
    end
    if (ackm) m_wd[m] = 0;
    case (m_mode[m])
      0: if (trig) begin
        m_mode[m]  = 1;
        m_irq[m]   = 1'b1;
        m_cause[m] = st;
        if (m_fired[m] < 65535) m_fired[m]++;
        e.cyc   = cyc + 1;
        e.cause = st;
        e.fired = m_fired[m];
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      1: if (ackm) begin
        m_mode[m] = 2;
        m_irq[m]  = 1'b0;
      end
      default: m_mode[m] = 0;
    endcase
  endtask

  task automatic apply();
    model_step(0);
    model_step(1);
  endtask

  task automatic next_slot();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic random_phases(input int n);
    for (int p = 0; p < n; p++) begin
      int len     = $urandom_range(50, 600);
      bit [1:0] hold = 2'($urandom);
      int th_rate = ($urandom_range(0, 2) == 0) ? 0 : 150;
      int en_mode = $urandom_range(0, 5);
      for (int k = 0; k < len; k++) begin
        next_slot();
        for (int i = 0; i < NCH; i++) begin
          if (!hold[i] || $urandom_range(0, 199) == 0)
            cov[i*CW +: CW] = CW'($urandom);
        end
        tohost    = {$urandom, $urandom};
        tohost[0] = (th_rate != 0) && ($urandom_range(1, th_rate) == 1);
        if (en_mode == 0) enable = ($urandom_range(0, 9) != 0);
        else enable = (en_mode != 1);
        ack_a = m_irq[0] ? ($urandom_range(0, 7) == 0)
                         : ($urandom_range(0, 63) == 0);
        ack_b = m_irq[1] ? ($urandom_range(0, 7) == 0)
                         : ($urandom_range(0, 63) == 0);
        apply();
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    bit  prev[2];
    bit  d;
    ev_t e;
    prev[0] = 1'b0;
    prev[1] = 1'b0;
    forever begin
      @(negedge clock);
      for (int m = 0; m < 2; m++) begin
        d = get_irq(m);
        check($sformatf("irq_level[%0d]", m), int'(d), int'(m_irq[m]));
        check($sformatf("fired_level[%0d]", m), get_fired(m), m_fired[m]);
        if (d && !prev[m]) begin
          last_rise[m] = cyc;
          if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            check($sformatf("unexpected_rise[%0d]", m), 1, 0);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rise_cycle[%0d]", m), cyc, e.cyc);
            check($sformatf("rise_cause[%0d]", m),
                  int'(get_cause(m)), int'(e.cause));
            check($sformatf("rise_fired[%0d]", m), get_fired(m), e.fired);
          end
        end
        prev[m] = d;
      end
    end
  end

  initial begin
    int e0;
    int k;
    reset  = 1'b0;
    enable = 1'b0;
    cov    = '0;
    tohost = '0;
    ack_a  = 1'b0;
    ack_b  = 1'b0;
    model_reset();
    #12;
    check("reset_irq_a", int'(irq_a), 0);
    check("reset_cause_a", int'(cause_a), 0);
    check("reset_fired_a", int'(fired_a), 0);
    check("reset_irq_b", int'(irq_b), 0);
    check("reset_cause_b", int'(cause_b), 0);
    check("reset_fired_b", int'(fired_b), 0);

    last_rise[0] = -1;
    last_rise[1] = -1;
    next_slot();
    reset  = 1'b1;
    enable = 1'b1;
    cov[0*CW +: CW] = 8'd5;
    cov[1*CW +: CW] = 8'd1;
    apply();
    e0 = cyc + 1;
    for (int i = 0; i < 59; i++) begin
      next_slot();
      cov[1*CW +: CW] = cov[1*CW +: CW] + 8'd1;
      apply();
    end
    next_slot();
    check("stall_latency_any", last_rise[0], e0 + BW + 1);
    check("stall_cause_any", int'(cause_a), 1);
    check("stall_fired_any", int'(fired_a), 1);
    check("no_rise_all", last_rise[1], -1);
    apply();

    random_phases(40);

    k = 0;
    while (k < 500 && !irq_a) begin
      next_slot();
      tohost = '0;
      enable = 1'b1;
      ack_a  = 1'b0;
      ack_b  = 1'b0;
      apply();
      k++;
    end
    check("wait_assert_timeout", int'(irq_a), 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_irq", int'(irq_a), 0);
    check("async_reset_fired", int'(fired_a), 0);
    check("async_reset_cause", int'(cause_a), 0);
    next_slot();
    reset = 1'b1;
    apply();

    random_phases(12);
    next_slot();
    next_slot();
    check("queue_empty_any", q0.size(), 0);
    check("queue_empty_all", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cov_stall_monitor.md
Name: cov_stall_monitor

Overview:
- Multi-channel, parametrised successor to the fuzzing-bench coverage stagnation monitor.
- Watches NUM_CH coverage-summary probes plus a global watchdog, and raises a latched interrupt toward the core's msip when coverage stalls or the round stops progressing.
- The interrupt is held until the bench or DPI side acknowledges it, and the cause is reported.
- Sits in the simulation testbench between the SoC coverage probes, tohost, and the forced interrupt line.

Parameters:
- NUM_CH, 2: number of coverage channels.
- COV_W, 30: width of each coverage probe.
- CNT_W, 32: width of stall and watchdog counters. Counters saturate at all-ones.
- BASE_WAIT, 1000: base stall threshold in cycles.
- SCALE_SHIFT, 19: the threshold is scaled by (cov >> SCALE_SHIFT) + 1.
- WDOG_LIMIT, 50000: watchdog trigger threshold in cycles.
- ALL_MODE, 0: 0 = any stalled channel triggers; 1 = all channels must be stalled.

Ports:
- clock, input, 1: sole clock. All state updates on posedge.
- reset, input, 1: asynchronous, active-low reset. reset=0 clears all state immediately.
- enable, input, 1: when 0, counters and pre_cov freeze and no new trigger is taken.
- cov, input, NUM_CH*COV_W: channel i occupies bits [i*COV_W +: COV_W].
- tohost, input, 64: bit 0 = round finished.
- irq_ack, input, 1: acknowledge of a pending interrupt.
- irq, output, 1: latched interrupt request.
- irq_cause, output, NUM_CH+1: bit NUM_CH = watchdog hit; bits [NUM_CH-1:0] = per-channel stalled flags at trigger time.
- fired_count, output, 16: number of interrupts raised since reset. Saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pre_cov, stall counters and the watchdog go to 0.
  - State = IDLE; irq=0; irq_cause=0; fired_count=0.
- Per channel i, each posedge with enable=1:
  - If tohost[0]=1: count_i <= 0. Highest priority.
  - Else if cov_i != pre_cov_i: pre_cov_i <= cov_i and count_i <= 0.
  - Else: count_i <= sat(count_i + 1).
- Threshold:
  - thr_i = BASE_WAIT * ((cov_i >> SCALE_SHIFT) + 1).
  - Computed at CNT_W+COV_W bits; no truncation.
  - stalled_i = (count_i >= thr_i), using the registered count and the current cov.
- Watchdog, each posedge with enable=1:
  - If tohost[0]=1: wdog <= 0; else wdog <= sat(wdog + 1).
  - wd_hit = (wdog >= WDOG_LIMIT).
- Trigger = enable & ~tohost[0] & (wd_hit | (ALL_MODE ? &stalled : |stalled)).
- FSM states: IDLE, ASSERT, REARM.
  - IDLE, trigger=1: next state ASSERT. Registered outputs: irq <= 1, irq_cause <= {wd_hit, stalled}, fired_count <= sat(+1).
  - ASSERT: irq held at 1; irq_cause stable; counters keep running but cannot retrigger.
  - ASSERT, irq_ack=1: next state REARM. irq <= 0; all count_i and wdog <= 0 in the same edge; irq_cause is retained.
  - REARM: unconditional transition to IDLE after 1 cycle. Counters run normally; no trigger is taken.
- irq_ack outside ASSERT is ignored.
- irq_ack in ASSERT is honoured regardless of enable.
- Latency: irq rises on the edge after the one where a counter first reaches its threshold.
- Simultaneous events:
  - tohost[0] together with a threshold crossing: no trigger; counters clear.
  - tohost[0] together with irq_ack in ASSERT: ack honoured; counters clear.
  - A cov change in the cycle a trigger is taken: irq_cause captures the pre-edge stalled flags.
- Saturation: counters stop at 2^CNT_W-1 and never wrap. fired_count stops at 16'hFFFF.
- Reset mid-ASSERT: irq drops asynchronously; the block comes out of reset in IDLE.

Test Plan:
1. Stall threshold: NUM_CH=1, cov=5 written once then held, enable=1 → irq rises exactly 1001 cycles after the change edge; irq_cause=2'b01; fired_count=1.
2. Scaled threshold: cov=(1<<19) held → irq rises 2001 cycles after the change edge. Then pulse irq_ack → irq=0 next edge, counters reset, re-fires 2001 cycles later, fired_count=2.
3. tohost suppression: assert tohost[0] for one cycle at count=999 (cov<2^19) → no irq; count restarts from 0; irq rises 1001 cycles after the pulse.
4. Watchdog: cov changes every cycle, tohost=0 → irq rises at cycle 50001 with irq_cause = watchdog bit only. irq_ack → wdog cleared.
5. ALL_MODE=1, NUM_CH=2: ch0 held, ch1 toggled → no stall irq before the watchdog. Freeze ch1 500 cycles after ch0 → irq rises when ch1 reaches 1000, cause=3'b011.
6. Reset/enable: in ASSERT, drive reset=0 mid-cycle → irq=0 immediately, fired_count=0. Separately, enable=0 for 300 cycles during a stall → irq is delayed by exactly 300 cycles.
